d2_report_scheduler: RTL and testbench
======================================

// Module: d2_report_scheduler
// PURPOSE
//  Sequences a byte stream of level reports into a bank of skip-one safety processors.
//  Each report is broadcast to NUM_LANES skip lanes (lane k drops index k) plus one strict
//  lane (no skip). The block waits for the lanes' is_safe to settle and samples them.
//  It keeps part-1 (strict) and part-2 (any lane safe) counts for the whole input file.
// PARAMETERS
//  NUM_LANES  8   skip lanes instantiated externally; also max supported report length
//  COUNT_W    16  width of every report counter
// PORTS
//  clk           in   1          single clock
//  rst_n         in   1          async active-low reset
//  in_valid      in   1          input beat valid
//  in_ready      out  1          input beat accepted when in_valid&&in_ready
//  in_data       in   8          report value
//  in_last       in   1          beat is last value of its report
//  in_eof        in   1          with in_last: last report of file
//  read_val      out  8          broadcast to all lanes (registered)
//  en_processor  out  1          lane enable, one pulse per forwarded value (registered)
//  newline       out  1          lane end-of-report, with final en_processor pulse
//  lane_safe     in   NUM_LANES  is_safe of skip lanes 0..NUM_LANES-1
//  strict_safe   in   1          is_safe of strict lane
//  total_cnt     out  COUNT_W    reports completed
//  part1_cnt     out  COUNT_W    reports safe without skip
//  part2_cnt     out  COUNT_W    reports safe with <=1 skip
//  len_err       out  1          sticky: a report exceeded NUM_LANES values
//  done          out  1          high after eof report sampled, until reset
// BEHAVIOUR
//  Reset (async, rst_n=0): every output 0 immediately. State returns to STREAM on release.
//  in_ready reset value is 0; it rises the first cycle after release.
//  States (d2_pkg::sched_state_t): STREAM, SETTLE, SAMPLE, DONE.
//  STREAM: in_ready=1. An accepted beat at cycle t drives read_val=in_data and
//    en_processor=1 at t+1 (newline=in_last). The value counter len increments.
//    Last beat -> SETTLE.
//  SETTLE: in_ready=0, en_processor=0. The lanes register is_safe this cycle. -> SAMPLE.
//  SAMPLE: in_ready=0. Sample strict_safe and |lane_safe, then:
//    total+=1; part1+=strict_safe; part2+=(|lane_safe || strict_safe); len=0.
//    -> DONE if the report carried in_eof, else STREAM.
//  DONE: in_ready=0, done=1. Inputs are ignored.
//  Timing: 3-cycle bubble per report from last-beat accept to next accept.
//  Single-value report (in_last on first beat): bypass. Nothing is forwarded to the lanes;
//    en_processor stays 0. Counted safe for both parts next cycle (total, part1, part2 +1).
//    Stays in STREAM unless eof -> DONE. in_ready stays 1 (no bubble).
//  Length: a beat accepted while len==NUM_LANES sets len_err and is still forwarded.
//    The part-2 result for that report is unreliable but counted as sampled.
//    len saturates at NUM_LANES.
//  Counters wrap modulo 2^COUNT_W. len_err clears only on reset.
//  in_eof without in_last is ignored.
//  Reset during SETTLE/SAMPLE: the report is discarded, no count change. External lanes
//    share rst_n.
// CONFIGURATION
//  D2_PART1_COUNT_EN defined: strict_safe is sampled and part1_cnt counts as above.
//  Not defined: strict_safe is unused, part1_cnt is tied 0, and part2 = |lane_safe only.
//    The bypass path increments total and part2 only.
// STRUCTURE
//  d2_pkg: sched_state_t enum, BYTE_W=8 localparam.
//  Sub-module d2_report_counter: COUNT_W incrementing counter with async reset and inc
//    strobe; instantiated 3x.
//  FSM, length tracking and output registers live in d2_report_scheduler.
// TESTING (bench instantiates NUM_LANES processor_skippy lanes plus a strict lane)
//  1. Report 7 6 4 2 1 -> en_processor 5 pulses, newline on 5th; total=1 part1=1 part2=1.
//  2. Report 1 2 7 8 9 -> total=1, part1=0, part2=0.
//  3. Report 1 3 2 4 5 -> part1=0, part2=1.
//  4. Report "5" alone -> no en_processor pulse; next cycle total=1 part1=1 part2=1.
//     in_ready never drops.
//  5. Two back-to-back reports, in_valid held high -> in_ready low exactly 3 cycles after
//     each last beat. No beat lost or duplicated; eof on 2nd report -> done=1.
//  6. Report of NUM_LANES+1 values -> len_err=1 from the cycle after the extra beat, total+=1.
//  7. rst_n asserted mid-report -> all outputs 0 without a clock edge.
//     Re-run test 1 -> counts 1/1/1.

Source files
------------

// File: rtl/d2_report_scheduler_pkg.sv
// Shared types for the day-2 report scheduler slice.
// Build option: D2_PART1_COUNT_EN enables the strict (part-1) count.
package d2_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      STREAM,
      SETTLE,
      SAMPLE,
      DONE
   } sched_state_t;

endpackage

// File: rtl/d2_report_scheduler_if.sv
// Report byte-stream handshake between a source and the scheduler.
// Build option: D2_PART1_COUNT_EN (no effect on this file).
interface d2_report_scheduler_if;
   import d2_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [BYTE_W-1:0] in_data;
   logic              in_last;
   logic              in_eof;

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      output in_eof,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      input  in_eof,
      output in_ready
   );

endinterface

// File: rtl/d2_report_scheduler_counter.sv
// Wrapping report counter with a single-cycle increment strobe.
// Build option: D2_PART1_COUNT_EN (no effect on this file).
module d2_report_counter #(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_inc,
   output logic [COUNT_W-1:0] o_cnt
);

   logic [COUNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + COUNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/d2_report_scheduler.sv
// Feeds level reports to skip-one safety lanes and tallies safe reports.
// Build option: D2_PART1_COUNT_EN enables strict_safe sampling and part1_cnt.
module d2_report_scheduler
   import d2_pkg::*;
#(
   parameter int NUM_LANES = 8,
   parameter int COUNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   d2_report_scheduler_if.slave s_in,
   output logic [BYTE_W-1:0]    read_val,
   output logic                 en_processor,
   output logic                 newline,
   input  logic [NUM_LANES-1:0] lane_safe,
   input  logic                 strict_safe,
   output logic [COUNT_W-1:0]   total_cnt,
   output logic [COUNT_W-1:0]   part1_cnt,
   output logic [COUNT_W-1:0]   part2_cnt,
   output logic                 len_err,
   output logic                 done
);

   localparam int LEN_W = $clog2(NUM_LANES + 1);

   sched_state_t      r_state;
   logic              r_in_ready;
   logic [BYTE_W-1:0] r_read_val;
   logic              r_en;
   logic              r_nl;
   logic [LEN_W-1:0]  r_len;
   logic              r_eof;
   logic              r_len_err;
   logic              r_done;

   logic w_acc;
   logic w_byp;
   logic w_len_full;
   logic w_smp;
   logic w_any;
   logic w_inc0;
   logic w_inc1;
   logic w_inc2;

   assign w_acc = s_in.in_valid && r_in_ready
               && (r_state == STREAM);
   assign w_byp = w_acc && s_in.in_last
               && (r_len == '0);
   assign w_len_full = (r_len == LEN_W'(NUM_LANES));
   assign w_smp = (r_state == SAMPLE);
   assign w_any = |lane_safe;
   assign w_inc0 = w_byp || w_smp;

`ifdef D2_PART1_COUNT_EN
   assign w_inc1 = w_byp || (w_smp && strict_safe);
   assign w_inc2 = w_byp
                || (w_smp && (w_any || strict_safe));
`else
   logic w_unused_strict;
   assign w_unused_strict = strict_safe;
   assign w_inc1 = 1'b0;
   assign w_inc2 = w_byp || (w_smp && w_any);
`endif

   // in_ready is driven from the current state, so it lags one cycle
   // behind every return to STREAM (including reset release).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= STREAM;
         r_in_ready <= 1'b0;
         r_read_val <= '0;
         r_en       <= 1'b0;
         r_nl       <= 1'b0;
         r_len      <= '0;
         r_eof      <= 1'b0;
         r_len_err  <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_en <= 1'b0;
         r_nl <= 1'b0;
         unique case (r_state)
            STREAM: begin
               r_in_ready <= 1'b1;
               if (w_byp) begin
                  if (s_in.in_eof) begin
                     r_state    <= DONE;
                     r_in_ready <= 1'b0;
                     r_done     <= 1'b1;
                  end
               end else if (w_acc) begin
                  r_read_val <= s_in.in_data;
                  r_en       <= 1'b1;
                  r_nl       <= s_in.in_last;
                  if (w_len_full) begin
                     r_len_err <= 1'b1;
                  end else begin
                     r_len <= r_len + LEN_W'(1);
                  end
                  if (s_in.in_last) begin
                     r_eof      <= s_in.in_eof;
                     r_state    <= SETTLE;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            SETTLE: begin
               r_in_ready <= 1'b0;
               r_state    <= SAMPLE;
            end
            SAMPLE: begin
               r_in_ready <= 1'b0;
               r_len      <= '0;
               if (r_eof) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= STREAM;
               end
            end
            DONE: begin
               r_in_ready <= 1'b0;
               r_done     <= 1'b1;
            end
            default: begin
               r_state <= STREAM;
            end
         endcase
      end
   end

   assign s_in.in_ready = r_in_ready;
   assign read_val      = r_read_val;
   assign en_processor  = r_en;
   assign newline       = r_nl;
   assign len_err       = r_len_err;
   assign done          = r_done;

   d2_report_counter #(.COUNT_W(COUNT_W)) u_total (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_inc0),
      .o_cnt (total_cnt)
   );

   d2_report_counter #(.COUNT_W(COUNT_W)) u_part1 (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_inc1),
      .o_cnt (part1_cnt)
   );

   d2_report_counter #(.COUNT_W(COUNT_W)) u_part2 (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_inc2),
      .o_cnt (part2_cnt)
   );

endmodule

// File: tb/tb_d2_report_scheduler.sv
// Scoreboard bench for d2_report_scheduler with behavioural safety lanes.
// Build option: D2_PART1_COUNT_EN selects the expected part-1 behaviour.
module tb_d2_report_scheduler;
   import d2_pkg::*;

   localparam int NL = 8;
   localparam int CW = 16;
`ifdef D2_PART1_COUNT_EN
   localparam bit P1EN = 1'b1;
`else
   localparam bit P1EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   d2_report_scheduler_if u_if ();

   logic [7:0]    read_val;
   logic          en_processor;
   logic          newline;
   logic [NL-1:0] lane_safe;
   logic          strict_safe;
   logic [CW-1:0] total_cnt;
   logic [CW-1:0] part1_cnt;
   logic [CW-1:0] part2_cnt;
   logic          len_err;
   logic          done;

   d2_report_scheduler #(.NUM_LANES(NL), .COUNT_W(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_in         (u_if),
      .read_val     (read_val),
      .en_processor (en_processor),
      .newline      (newline),
      .lane_safe    (lane_safe),
      .strict_safe  (strict_safe),
      .total_cnt    (total_cnt),
      .part1_cnt    (part1_cnt),
      .part2_cnt    (part2_cnt),
      .len_err      (len_err),
      .done         (done)
   );

   // Behavioural lanes: skip lane k ignores index k, strict lane skips none.
   logic [7:0] lb [16];
   int ln;

   function automatic bit seq_safe(int skip, int n, logic [7:0] lastv);
      int prev, cnt, dir, v, d, s;
      bit ok;
      ok = 1'b1; cnt = 0; dir = 0; prev = 0;
      for (int i = 0; i < n; i++) begin
         if (i == skip) continue;
         v = (i == n - 1) ? int'(lastv) : int'(lb[i]);
         if (cnt > 0) begin
            d = v - prev;
            if (d == 0 || d > 3 || d < -3) ok = 1'b0;
            s = (d > 0) ? 1 : -1;
            if (cnt == 1) dir = s;
            else if (s != dir) ok = 1'b0;
         end
         prev = v;
         cnt++;
      end
      return ok;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ln <= 0;
         lane_safe <= '0;
         strict_safe <= 1'b0;
      end else if (en_processor) begin
         if (ln < 16) lb[ln] <= read_val;
         if (newline) begin
            for (int k = 0; k < NL; k++)
               lane_safe[k] <= seq_safe(k, ln + 1, read_val);
            strict_safe <= seq_safe(-1, ln + 1, read_val);
            ln <= 0;
         end else begin
            ln <= ln + 1;
         end
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   typedef struct packed { logic [7:0] v; logic nl; } beat_t;
   typedef struct packed { logic [15:0] t; logic [15:0] p1; logic [15:0] p2; } cnt_t;
   beat_t q_beat [$];
   cnt_t  q_cnt [$];
   int n_en = 0;
   logic [CW-1:0] prev_tot = '0;

   // Monitor: forwarded beats and counter updates against the queues.
   always @(negedge clk) begin
      beat_t b;
      cnt_t c;
      if (!rst_n) begin
         prev_tot = '0;
      end else begin
         if (en_processor) begin
            n_en++;
            if (q_beat.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL beat_unexpected: got %0h want none", read_val);
            end else begin
               b = q_beat.pop_front();
               chk("read_val", read_val, b.v);
               chk("newline", newline, b.nl);
            end
         end
         if (total_cnt != prev_tot) begin
            if (q_cnt.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL cnt_unexpected: got total %0d want none", total_cnt);
            end else begin
               c = q_cnt.pop_front();
               chk("total_cnt", total_cnt, c.t);
               chk("part1_cnt", part1_cnt, c.p1);
               chk("part2_cnt", part2_cnt, c.p2);
            end
            prev_tot = total_cnt;
         end
      end
   end

   logic [7:0] rep [16];
   int pos = 0;
   int e_tot, e_p1, e_p2;
   time t_acc;

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send_beat(input logic [7:0] v, input bit last, input bit eof);
      int w;
      beat_t b;
      u_if.in_valid = 1'b1;
      u_if.in_data = v;
      u_if.in_last = last;
      u_if.in_eof = eof;
      w = 0;
      forever begin
         @(negedge clk);
         if (u_if.in_ready) break;
         w++;
         if (w > 40) break;
      end
      if (w > 40) begin
         n_cmp++; n_err++;
         $display("FAIL accept_timeout: got no in_ready want accept of %0h", v);
         @(posedge clk); #1;
         return;
      end
      t_acc = $time;
      @(posedge clk); #1;
      if (!(last && pos == 0)) begin
         b.v = v; b.nl = last;
         q_beat.push_back(b);
      end
      pos = last ? 0 : pos + 1;
   endtask

   task automatic exp_report(input bit s, input bit p2);
      cnt_t c;
      e_tot++;
      if (s && P1EN) e_p1++;
      if (p2) e_p2++;
      c.t = 16'(e_tot); c.p1 = 16'(e_p1); c.p2 = 16'(e_p2);
      q_cnt.push_back(c);
   endtask

   task automatic send_report(input int n, input bit eof, input bit mid_eof,
                              input bit s, input bit p2, input bit keep);
      for (int i = 0; i < n; i++)
         send_beat(rep[i], i == n - 1, (i == n - 1) ? eof : mid_eof);
      exp_report(s, p2);
      if (!keep) begin
         u_if.in_valid = 1'b0;
         u_if.in_last = 1'b0;
         u_if.in_eof = 1'b0;
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
      end
      #1;
   endtask

   task automatic do_reset(input bit drain);
      if (drain) begin
         chk("beat_q_drained", q_beat.size(), 0);
         chk("cnt_q_drained", q_cnt.size(), 0);
      end
      u_if.in_valid = 1'b0;
      u_if.in_last = 1'b0;
      u_if.in_eof = 1'b0;
      u_if.in_data = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      chk("reset_outputs",
          {u_if.in_ready, read_val, en_processor, newline, total_cnt,
           part1_cnt, part2_cnt, len_err, done}, 64'd0);
      q_beat.delete();
      q_cnt.delete();
      pos = 0; e_tot = 0; e_p1 = 0; e_p2 = 0; n_en = 0;
      rst_n = 1'b1;
      #1 chk("ready_at_release", u_if.in_ready, 1'b0);
      @(posedge clk); #1;
      chk("ready_after_release", u_if.in_ready, 1'b1);
   endtask

   task automatic load5(input logic [7:0] a, b, c, d, e);
      rep[0] = a; rep[1] = b; rep[2] = c; rep[3] = d; rep[4] = e;
   endtask

   time t_last1;

   initial begin
      u_if.in_valid = 1'b0;
      u_if.in_data = '0;
      u_if.in_last = 1'b0;
      u_if.in_eof = 1'b0;
      #12;

      do_reset(1'b0);
      load5(7, 6, 4, 2, 1);
      send_report(5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_cyc(6);
      chk("t1_en_pulses", n_en, 5);
      chk("t1_done", done, 1'b0);
      chk("t1_part2", part2_cnt, 1);

      do_reset(1'b1);
      load5(1, 2, 7, 8, 9);
      send_report(5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_cyc(6);
      chk("t2_total", total_cnt, 1);

      do_reset(1'b1);
      load5(1, 3, 2, 4, 5);
      send_report(5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      wait_cyc(6);
      chk("t3_part1", part1_cnt, 0);

      do_reset(1'b1);
      rep[0] = 5;
      send_report(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("t4_ready_held", u_if.in_ready, 1'b1);
         wait_cyc(1);
      end
      chk("t4_en_pulses", n_en, 0);
      chk("t4_total", total_cnt, 1);

      do_reset(1'b1);
      load5(1, 3, 6, 7, 9);
      send_report(5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      t_last1 = t_acc;
      load5(8, 6, 4, 4, 1);
      send_beat(rep[0], 1'b0, 1'b0);
      chk("t5_bubble_cycles", 64'((t_acc - t_last1) / 10), 4);
      for (int i = 1; i < 5; i++)
         send_beat(rep[i], i == 4, i == 4);
      exp_report(1'b0, 1'b1);
      wait_cyc(6);
      chk("t5_done", done, 1'b1);
      chk("t5_en_pulses", n_en, 10);
      u_if.in_valid = 1'b1;
      u_if.in_last = 1'b1;
      u_if.in_data = 8'h33;
      wait_cyc(3);
      chk("t5_done_ready", u_if.in_ready, 1'b0);
      chk("t5_done_en", n_en, 10);
      u_if.in_valid = 1'b0;

      do_reset(1'b1);
      for (int i = 0; i < NL; i++)
         send_beat(8'(i + 1), 1'b0, 1'b0);
      chk("t6_len_err_before", len_err, 1'b0);
      send_beat(8'(NL + 1), 1'b1, 1'b0);
      exp_report(1'b1, 1'b1);
      u_if.in_valid = 1'b0;
      u_if.in_last = 1'b0;
      @(negedge clk);
      chk("t6_len_err_after", len_err, 1'b1);
      wait_cyc(6);
      chk("t6_total", total_cnt, 1);
      chk("t6_len_err_sticky", len_err, 1'b1);

      do_reset(1'b1);
      load5(7, 6, 4, 2, 1);
      send_report(5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_cyc(5);
      send_beat(8'd1, 1'b0, 1'b0);
      send_beat(8'd3, 1'b0, 1'b0);
      u_if.in_valid = 1'b0;
      chk("t7_en_before_rst", en_processor, 1'b1);
      chk("t7_total_before_rst", total_cnt, 1);
      #1 rst_n = 1'b0;
      #1 chk("t7_async_reset",
             {u_if.in_ready, read_val, en_processor, newline, total_cnt,
              part1_cnt, part2_cnt, len_err, done}, 64'd0);
      chk("t7_pending_beat", q_beat.size(), 1);
      do_reset(1'b0);
      load5(7, 6, 4, 2, 1);
      send_report(5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_cyc(6);
      chk("t7_total", total_cnt, 1);
      chk("t7_part1", part1_cnt, P1EN ? 1 : 0);
      chk("t7_part2", part2_cnt, 1);
      chk("t7_beat_q_drained", q_beat.size(), 0);
      chk("t7_cnt_q_drained", q_cnt.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
